// File: rtl/hoop_pkg.sv
// Shared definitions for the hoop game: round state encoding and default timing.
// Used by the round controller, its debouncers and the display blocks.
package hoop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

   localparam int unsigned DEF_TICK_DIV  = 50_000_000;
   localparam int unsigned DEF_GAME_SECS = 30;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hoop_debounce.sv
// One hoop channel: 2-flop synchroniser, stability counter, rising-edge strobe.
// Raw edge to strobe takes 2 + DEBOUNCE_CYC + 1 cycles; no backpressure.
module hoop_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic strobe
);
   import hoop_pkg::*;

   localparam int unsigned CW      = cnt_w(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

   logic          meta_q, meta_d;
   logic          sync_q, sync_d;
   logic          cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          acc_q, acc_d;
   logic          acc_dly_q, acc_dly_d;
   logic          strobe_q, strobe_d;

   // cnt_q is the run length of identical synchronised samples, capped at DEBOUNCE_CYC.
   always_comb begin
      meta_d    = raw;
      sync_d    = meta_q;
      cand_d    = sync_q;
      cnt_d     = CW'(1);
      if (sync_q == cand_q) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
      acc_d     = (cnt_d == CNT_MAX) ? sync_q : acc_q;
      acc_dly_d = acc_q;
      strobe_d  = acc_q & ~acc_dly_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q    <= 1'b0;
         sync_q    <= 1'b0;
         cand_q    <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= 1'b0;
         acc_dly_q <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         acc_dly_q <= acc_dly_d;
         strobe_q  <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule

// File: rtl/hoop_round_ctrl.sv
// Game-round controller: countdown timer, N-channel scoring with final-seconds bonus, pause/restart.
// All outputs registered; game_over is a one-cycle pulse on entry to OVER; no backpressure.
module hoop_round_ctrl
   import hoop_pkg::*;
#(
   parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
   parameter int unsigned GAME_SECS    = DEF_GAME_SECS,
   parameter int unsigned N_HOOPS      = 3,
   parameter int unsigned SCORE_W      = 8,
   parameter int unsigned DEBOUNCE_CYC = 1000,
   parameter int unsigned BONUS_SECS   = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic [N_HOOPS-1:0] hoop_in,
   output logic [7:0]         time_left,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] final_score,
   output logic               running,
   output logic               game_over
);

   localparam int unsigned      PW         = cnt_w(TICK_DIV);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0]       TIME_INIT  = 8'(GAME_SECS);
   localparam logic [7:0]       BONUS_TH   = 8'(BONUS_SECS);
   localparam int unsigned      SUM_W      = SCORE_W + 4;
   localparam logic [SUM_W-1:0] SCORE_MAX  = {4'b0000, {SCORE_W{1'b1}}};

   logic [N_HOOPS-1:0] strobe;

   for (genvar g = 0; g < N_HOOPS; g++) begin : g_hoop
      hoop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
         .clock  (clock),
         .reset  (reset),
         .raw    (hoop_in[g]),
         .strobe (strobe[g])
      );
   end

   state_e             state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [7:0]         time_q, time_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] final_q, final_d;
   logic               running_q, running_d;
   logic               game_over_q, game_over_d;
   logic               start_prev_q, start_prev_d;

   logic               start_edge;
   logic [3:0]         basket_cnt;
   logic [SUM_W-1:0]   incr;
   logic [SUM_W-1:0]   sum;
   logic [SCORE_W-1:0] score_sat;

   always_comb begin
      basket_cnt = 4'd0;
      for (int i = 0; i < int'(N_HOOPS); i++) begin
         basket_cnt = basket_cnt + {3'b000, strobe[i]};
      end
      incr      = (time_q <= BONUS_TH) ? SUM_W'({basket_cnt, 1'b0}) : SUM_W'(basket_cnt);
      sum       = {4'b0000, score_q} + incr;
      score_sat = (sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
   end

   assign start_edge = start & ~start_prev_q;

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      time_d       = time_q;
      score_d      = score_q;
      final_d      = final_q;
      game_over_d  = 1'b0;
      start_prev_d = start;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_edge) begin
               state_d = ST_RUN;
               presc_d = '0;
               time_d  = TIME_INIT;
               score_d = '0;
            end
         end
         ST_RUN: begin
            // pause takes priority over both the tick and any basket this cycle
            if (pause) begin
               state_d = ST_PAUSED;
            end else begin
               score_d = score_sat;
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  time_d  = time_q - 8'd1;
                  if (time_q == 8'd1) begin
                     state_d     = ST_OVER;
                     final_d     = score_sat;
                     game_over_d = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
         end
         ST_PAUSED: begin
            if (!pause) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         time_q       <= TIME_INIT;
         score_q      <= '0;
         final_q      <= '0;
         running_q    <= 1'b0;
         game_over_q  <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         time_q       <= time_d;
         score_q      <= score_d;
         final_q      <= final_d;
         running_q    <= running_d;
         game_over_q  <= game_over_d;
         start_prev_q <= start_prev_d;
      end
   end

   assign time_left   = time_q;
   assign score       = score_q;
   assign final_score = final_q;
   assign running     = running_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_hoop_round_ctrl.sv
// Bench for hoop_round_ctrl: directed scenarios plus random play against a cycle-level game model.
// A second instance with a 4-bit score exercises saturation on the same stimulus.
module tb_hoop_round_ctrl;

   localparam int TD = 10;
   localparam int GS = 5;
   localparam int NH = 3;
   localparam int DC = 4;
   localparam int BS = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic [NH-1:0] hoop_in = '0;

   logic [7:0] time_a, time_b;
   logic [7:0] score_a, final_a;
   logic [3:0] score_b, final_b;
   logic       run_a, run_b, go_a, go_b;

   hoop_round_ctrl #(.TICK_DIV(TD), .GAME_SECS(GS), .N_HOOPS(NH), .SCORE_W(8),
                     .DEBOUNCE_CYC(DC), .BONUS_SECS(BS)) u_dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause), .hoop_in(hoop_in),
      .time_left(time_a), .score(score_a), .final_score(final_a),
      .running(run_a), .game_over(go_a));

   hoop_round_ctrl #(.TICK_DIV(TD), .GAME_SECS(GS), .N_HOOPS(NH), .SCORE_W(4),
                     .DEBOUNCE_CYC(DC), .BONUS_SECS(BS)) u_sat (
      .clock(clock), .reset(reset), .start(start), .pause(pause), .hoop_in(hoop_in),
      .time_left(time_b), .score(score_b), .final_score(final_b),
      .running(run_b), .game_over(go_b));

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   int cyc = 0;

   always @(posedge clock) cyc++;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_state, m_presc, m_time, m_go;
   bit m_start_prev;
   int m_score[2], m_final[2];
   int m_max[2] = '{255, 15};
   bit m_hist[NH][DC+2];
   bit m_acc[NH], m_acc_old[NH], m_strobe[NH];
   int nb;
   bit sedge, all_eq, new_acc;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_state = M_IDLE; m_presc = 0; m_time = GS; m_go = 0; m_start_prev = 0;
         for (int k = 0; k < 2; k++) begin m_score[k] = 0; m_final[k] = 0; end
         for (int c = 0; c < NH; c++) begin
            for (int j = 0; j < DC + 2; j++) m_hist[c][j] = 0;
            m_acc[c] = 0; m_acc_old[c] = 0; m_strobe[c] = 0;
         end
      end else begin
         sedge = start && !m_start_prev;
         m_start_prev = start;
         m_go = 0;
         nb = 0;
         for (int c = 0; c < NH; c++) nb += int'(m_strobe[c]);
         case (m_state)
            M_IDLE, M_OVER: if (sedge) begin
               m_state = M_RUN; m_time = GS; m_presc = 0;
               m_score[0] = 0; m_score[1] = 0;
            end
            M_RUN: if (pause) m_state = M_PAUSED;
            else begin
               for (int k = 0; k < 2; k++) begin
                  m_score[k] += nb * ((m_time <= BS) ? 2 : 1);
                  if (m_score[k] > m_max[k]) m_score[k] = m_max[k];
               end
               if (m_presc == TD - 1) begin
                  m_presc = 0;
                  m_time--;
                  if (m_time == 0) begin
                     m_state = M_OVER; m_go = 1;
                     m_final[0] = m_score[0]; m_final[1] = m_score[1];
                  end
               end else m_presc++;
            end
            M_PAUSED: if (!pause) m_state = M_RUN;
            default: m_state = M_IDLE;
         endcase
         // debounce: a level is accepted once DC consecutive synchronised samples agree;
         // the synchroniser makes the sample seen now the raw value from two edges ago
         for (int c = 0; c < NH; c++) begin
            for (int j = DC + 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = hoop_in[c];
            all_eq = 1;
            for (int j = 2; j <= DC + 1; j++) if (m_hist[c][j] != m_hist[c][2]) all_eq = 0;
            new_acc = all_eq ? m_hist[c][2] : m_acc[c];
            m_strobe[c] = m_acc[c] & ~m_acc_old[c];
            m_acc_old[c] = m_acc[c];
            m_acc[c] = new_acc;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         check("time_left", int'(time_a), m_time);
         check("score", int'(score_a), m_score[0]);
         check("final_score", int'(final_a), m_final[0]);
         check("running", int'(run_a), int'(m_state == M_RUN));
         check("game_over", int'(go_a), m_go);
         check("score_w4", int'(score_b), m_score[1]);
         check("final_w4", int'(final_b), m_final[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_time(input int v);
      int n = 0;
      while (int'(time_a) != v && n < 200) begin step(); n++; end
      if (n >= 200) check("wait_time_timeout", int'(time_a), v);
   endtask

   task automatic wait_go(output int n);
      n = 0;
      while (!go_a && n < 300) begin step(); n++; end
      if (n >= 300) check("wait_go_timeout", int'(go_a), 1);
   endtask

   int n_go, t0;

   initial begin
      #1 reset = 1'b0;
      repeat (3) step();
      chk_on = 1'b1;
      check("rst_time", int'(time_a), 5);
      check("rst_score", int'(score_a), 0);
      check("rst_running", int'(run_a), 0);
      check("rst_game_over", int'(go_a), 0);
      reset = 1'b1;
      repeat (20) step();
      check("idle_time", int'(time_a), 5);
      check("idle_running", int'(run_a), 0);

      // plain round: 50 cycles from start edge to game_over
      pulse_start();
      check("run_after_start", int'(run_a), 1);
      wait_go(n_go);
      check("round_cycles", n_go, 50);
      check("over_running", int'(run_a), 0);
      check("over_time", int'(time_a), 0);
      check("over_final0", int'(final_a), 0);
      step();
      check("go_one_cycle", int'(go_a), 0);

      // single channel: +1 at time 4, glitch ignored, +2 at time 2
      pulse_start();
      wait_time(4);
      hoop_in[0] = 1'b1; repeat (8) step(); hoop_in[0] = 1'b0;
      check("basket_t4", int'(score_a), 1);
      wait_time(3);
      hoop_in[0] = 1'b1; repeat (2) step(); hoop_in[0] = 1'b0;
      repeat (7) step();
      check("glitch_ignored", int'(score_a), 1);
      wait_time(2);
      hoop_in[0] = 1'b1; repeat (8) step(); hoop_in[0] = 1'b0;
      check("bonus_t2", int'(score_a), 3);
      wait_go(n_go);
      check("final_single", int'(final_a), 3);

      // all channels together: +3 at time 3, +6 at time 1
      pulse_start();
      wait_time(3);
      hoop_in = 3'b111; repeat (8) step(); hoop_in = 3'b000;
      check("triple_t3", int'(score_a), 3);
      wait_time(1);
      hoop_in = 3'b111; repeat (8) step(); hoop_in = 3'b000;
      check("triple_t1", int'(score_a), 9);
      wait_go(n_go);
      check("final_triple", int'(final_a), 9);

      // pause 37 cycles at time 3 with a basket during the pause
      pulse_start();
      t0 = cyc;
      wait_time(3);
      pause = 1'b1;
      hoop_in[1] = 1'b1; repeat (8) step(); hoop_in[1] = 1'b0;
      repeat (29) step();
      check("paused_time", int'(time_a), 3);
      check("paused_score", int'(score_a), 0);
      check("paused_running", int'(run_a), 0);
      pause = 1'b0;
      wait_go(n_go);
      check("pause_round_cycles", cyc - t0, 88);
      check("pause_final", int'(final_a), 0);

      // five triple baskets: 3+3+3+6+6 = 21; 4-bit instance saturates at 15
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         hoop_in = 3'b111; repeat (5) step();
         hoop_in = 3'b000; repeat (5) step();
      end
      check("sat_go", int'(go_a), 1);
      check("sat_final8", int'(final_a), 21);
      check("sat_final4", int'(final_b), 15);
      pulse_start();
      check("restart_score", int'(score_a), 0);
      check("restart_time", int'(time_a), 5);
      check("restart_running", int'(run_a), 1);
      check("restart_final_hold", int'(final_a), 21);

      // reset mid-round: outputs return at once
      repeat (13) step();
      reset = 1'b0;
      #1;
      check("midrst_time", int'(time_a), 5);
      check("midrst_score", int'(score_a), 0);
      check("midrst_final", int'(final_a), 0);
      check("midrst_running", int'(run_a), 0);
      check("midrst_go", int'(go_a), 0);
      step();
      reset = 1'b1;
      step();

      // random play
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) pause = ~pause;
         for (int c = 0; c < NH; c++)
            if ($urandom_range(0, 5) == 0) hoop_in[c] = ~hoop_in[c];
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b0; step(); reset = 1'b1;
         end
         step();
      end
      start = 1'b0; pause = 1'b0; hoop_in = '0;
      repeat (3) step();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
